paws_reset_sequencer: RTL

- Sits directly downstream of the system PLL; consumes its raw `locked` output.
- Produces ordered, glitch-free, registered reset releases for the SDRAM controller, the I/O block and the CPU/system core.
- Enforces the SDRAM power-up wait (200 us at 50 MHz) before the controller leaves reset.
- Counts lock-loss events for a status register.
- Runs on the 50 MHz system clock. Consumers in other clock domains (150 MHz SDRAM) re-synchronise these outputs locally.

---
 rtl/paws_clk_pkg.sv | 28 ++
 rtl/paws_sync_bit.sv | 26 ++
 rtl/paws_reset_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/paws_clk_pkg.sv
// Shared clocking/reset definitions: sequencer states, system clock constants, SDRAM power-up wait.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package paws_clk_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK  = 3'd0,
      ST_STABLE     = 3'd1,
      ST_SDRAM_WAIT = 3'd2,
      ST_IO_GAP     = 3'd3,
      ST_RUN        = 3'd4
   } state_t;

   localparam int SYS_CLK_HZ        = 50_000_000;
   localparam int SDRAM_POWERUP_US  = 200;
   // 200 us at 50 MHz = 10000 cycles
   localparam int SDRAM_WAIT_CYCLES = (SYS_CLK_HZ / 1_000_000) * SDRAM_POWERUP_US;

   // Width of a down-counter that can hold the largest of three cycle counts, plus one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/paws_sync_bit.sv
// N-flop single-bit synchroniser with synchronous active-high clear.
// Latency: STAGES cycles from d to q.
// Backpressure: none; free-running.
module paws_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic clear,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   // shift the asynchronous input through the flop chain; clear empties it
   always_ff @(posedge clock) begin
      if (clear) begin
         sync <= '0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
      end
   end

   assign q = sync[STAGES-1];

endmodule

// File: rtl/paws_reset_sequencer.sv
// Ordered reset release (sdram, io, system) after a stable PLL lock; counts lock losses.
// Latency: rst_sdram falls SYNC_STAGES+1+LOCK_STABLE_CYCLES cycles after a raw lock rise; all outputs registered.
// Backpressure: none; sw_reset is a one-cycle pulse acted on only in IO_GAP or RUN.
module paws_reset_sequencer
   import paws_clk_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int SDRAM_WAIT_CYCLES  = paws_clk_pkg::SDRAM_WAIT_CYCLES,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pll_locked,
   input  logic                  sw_reset,
   output logic                  rst_sdram,
   output logic                  rst_io,
   output logic                  rst_system,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] lock_loss_count
);

   localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, SDRAM_WAIT_CYCLES, STAGE_GAP_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_STABLE = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_SDRAM  = CNT_W'(SDRAM_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_GAP    = CNT_W'(STAGE_GAP_CYCLES - 1);

   logic             lk;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             io_pulse;
   logic             loss_evt;
   logic             rst_sdram_nxt, rst_io_nxt, rst_system_nxt, ready_nxt;

   paws_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clock (clock),
      .clear (reset),
      .d     (pll_locked),
      .q     (lk)
   );

   // next-state, shared counter and next-output decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      io_pulse  = 1'b0;
      loss_evt  = 1'b0;

      if (!lk && (state == ST_SDRAM_WAIT || state == ST_IO_GAP || state == ST_RUN)) begin
         // lock loss after release wins over sw_reset
         state_nxt = ST_WAIT_LOCK;
         loss_evt  = 1'b1;
      end else if (sw_reset && (state == ST_IO_GAP || state == ST_RUN)) begin
         state_nxt = ST_IO_GAP;
         cnt_nxt   = LOAD_GAP;
         io_pulse  = 1'b1;
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (lk) begin
                  state_nxt = ST_STABLE;
                  cnt_nxt   = LOAD_STABLE;
               end
            end
            ST_STABLE: begin
               if (!lk) begin
                  state_nxt = ST_WAIT_LOCK;
               end else if (cnt == '0) begin
                  state_nxt = ST_SDRAM_WAIT;
                  cnt_nxt   = LOAD_SDRAM;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            ST_SDRAM_WAIT: begin
               if (cnt == '0) begin
                  state_nxt = ST_IO_GAP;
                  cnt_nxt   = LOAD_GAP;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            ST_IO_GAP: begin
               // rst_io high here marks the sw_reset pulse cycle: the gap count
               // starts after it, so the system is held one extra cycle
               if (!rst_io) begin
                  if (cnt == '0) begin
                     state_nxt = ST_RUN;
                  end else begin
                     cnt_nxt = cnt - 1'b1;
                  end
               end
            end
            ST_RUN: begin
               state_nxt = ST_RUN;
            end
            default: begin
               state_nxt = ST_WAIT_LOCK;
            end
         endcase
      end

      rst_sdram_nxt  = (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_STABLE);
      rst_io_nxt     = rst_sdram_nxt || (state_nxt == ST_SDRAM_WAIT) || io_pulse;
      rst_system_nxt = (state_nxt != ST_RUN);
      ready_nxt      = (state_nxt == ST_RUN);
   end

   // state, counter, registered outputs and saturating lock-loss count
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_WAIT_LOCK;
         cnt             <= '0;
         rst_sdram       <= 1'b1;
         rst_io          <= 1'b1;
         rst_system      <= 1'b1;
         ready           <= 1'b0;
         lock_loss_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         rst_sdram  <= rst_sdram_nxt;
         rst_io     <= rst_io_nxt;
         rst_system <= rst_system_nxt;
         ready      <= ready_nxt;
         if (loss_evt && (lock_loss_count != '1)) begin
            lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
         end
      end
   end

endmodule
